// File: rtl/sreg_ctl.sv
// Two-requester round-robin load controller for an N-bit serial shift register.
// Presets the register, shifts the granted word in MSB-first, then pulses DONE.
module sreg_ctl #(
   parameter int N  = 8,
   parameter int CW = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         REQ0,
   input  logic         REQ1,
   input  logic [N-1:0] DIN0,
   input  logic [N-1:0] DIN1,
   output logic         GNT0,
   output logic         GNT1,
   output logic         PRE,
   output logic         S0,
   output logic         LSBIN,
   output logic         BUSY,
   output logic         DONE,
   output logic         DONE_ID
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PRESET = 2'd1;
   localparam logic [1:0] SHIFT  = 2'd2;
   localparam logic [1:0] FIN    = 2'd3;

   logic [1:0]    state;
   logic [N-1:0]  hold;
   logic [CW-1:0] cnt;
   logic          owner;
   logic          last;
   logic          any_req;
   logic          win;
   logic [CW-1:0] idx;

   // On a tie the requester not served most recently wins.
   always_comb begin
      any_req = REQ0 | REQ1;
      win     = (REQ0 & REQ1) ? ~last : REQ1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         hold  <= '0;
         cnt   <= '0;
         owner <= 1'b0;
         last  <= 1'b1;
         GNT0  <= 1'b0;
         GNT1  <= 1'b0;
      end else begin
         GNT0 <= 1'b0;
         GNT1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  hold  <= win ? DIN1 : DIN0;
                  owner <= win;
                  last  <= win;
                  GNT0  <= ~win;
                  GNT1  <= win;
                  state <= PRESET;
               end
            end
            PRESET: begin
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N-1)) state <= FIN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; MSB of hold goes out first.
   always_comb begin
      idx     = CW'(N-1) - cnt;
      PRE     = (state == PRESET);
      S0      = (state == SHIFT);
      LSBIN   = (state == SHIFT) & hold[idx];
      BUSY    = (state != IDLE);
      DONE    = (state == FIN);
      DONE_ID = (state == FIN) & owner;
   end

endmodule

// File: tb/tb_sreg_ctl.sv
// Self-checking bench for sreg_ctl: transaction-level reference model plus a
// model of the downstream shift register, directed scenarios and random traffic.
module tb_sreg_ctl;
   localparam int N = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         REQ0 = 1'b0;
   logic         REQ1 = 1'b0;
   logic [N-1:0] DIN0 = '0;
   logic [N-1:0] DIN1 = '0;
   logic         GNT0, GNT1, PRE, S0, LSBIN, BUSY, DONE, DONE_ID;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: t = cycles since grant edge, -1 when idle
   int           t = -1;
   logic         m_last = 1'b1;
   logic         m_owner = 1'b0;
   logic [N-1:0] m_word = '0;

   // downstream shift register and the controls it saw last cycle
   logic [N-1:0] q = '0;
   logic         p_pre = 1'b0, p_s0 = 1'b0, p_lsbin = 1'b0;

   int           cyc = 0, done_cnt = 0, gnt0_cnt = 0, gnt1_cnt = 0, pre_cnt = 0, s0_idx = 0;
   int           last_done_cyc = 0, last_gnt1_cyc = 0;
   logic         last_id = 1'bx;
   logic [N-1:0] q_at_done = '0;
   logic [N-1:0] lsb_seq = '0;
   bit           auto_drop = 1'b1;
   int           done_cycs[$];
   int           gnt0_cycs[$];

   sreg_ctl #(.N(N), .CW(3)) dut (
      .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .DIN0(DIN0), .DIN1(DIN1),
      .GNT0(GNT0), .GNT1(GNT1), .PRE(PRE), .S0(S0), .LSBIN(LSBIN),
      .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      logic [7:0] e, g;
      logic       w;
      @(posedge CLK);
      #1;
      cyc++;
      if (p_pre) q = '1;
      else if (p_s0) q = {q[N-2:0], p_lsbin};
      if (RST) begin
         t = -1; m_last = 1'b1; m_owner = 1'b0;
      end else if (t < 0) begin
         if (REQ0 | REQ1) begin
            w = (REQ0 & REQ1) ? ~m_last : REQ1;
            m_owner = w;
            m_last  = w;
            m_word  = w ? DIN1 : DIN0;
            t = 0;
         end
      end else if (t == N + 1) t = -1;
      else t++;
      e = {(t == 0 && !m_owner), (t == 0 && m_owner), (t == 0), (t >= 1 && t <= N),
           ((t >= 1 && t <= N) ? m_word[N-t] : 1'b0), (t >= 0), (t == N + 1),
           (t == N + 1 && m_owner)};
      g = {GNT0, GNT1, PRE, S0, LSBIN, BUSY, DONE, DONE & DONE_ID};
      check("outs", g, e);
      if (t == N + 1) check("q_done", q, m_word);
      if (DONE) begin
         done_cnt++; last_done_cyc = cyc; last_id = DONE_ID; q_at_done = q;
         done_cycs.push_back(cyc);
      end
      if (GNT0) begin gnt0_cnt++; gnt0_cycs.push_back(cyc); end
      if (GNT1) begin gnt1_cnt++; last_gnt1_cyc = cyc; end
      if (PRE) pre_cnt++;
      if (S0) begin s0_idx++; lsb_seq = {lsb_seq[N-2:0], LSBIN}; end
      else s0_idx = 0;
      p_pre = PRE; p_s0 = S0; p_lsbin = LSBIN;
      if (auto_drop) begin
         if (GNT0) REQ0 = 1'b0;
         if (GNT1) REQ1 = 1'b0;
      end
   endtask

   task automatic run_until_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      check("done_timeout", done_cnt != d0, 1);
   endtask

   // asynchronous reset asserted mid-cycle, held over two edges, released mid-cycle
   task automatic do_reset();
      REQ0 = 1'b0; REQ1 = 1'b0;
      #2 RST = 1'b1;
      #1 check("rst_outs", {GNT0, GNT1, PRE, S0, LSBIN, BUSY, DONE, DONE_ID}, 0);
      t = -1; m_last = 1'b1; m_owner = 1'b0;
      p_pre = 1'b0; p_s0 = 1'b0; p_lsbin = 1'b0; s0_idx = 0;
      tick();
      tick();
      #2 RST = 1'b0;
   endtask

   initial begin
      int d, g1, gp, pp, prev_done;

      do_reset();

      // single load of 8'hA5
      gp = gnt0_cnt; pp = pre_cnt;
      DIN0 = 8'hA5; REQ0 = 1'b1;
      run_until_done(30);
      check("a5_lsbin_seq", lsb_seq, 8'hA5);
      check("a5_done_id", last_id, 0);
      check("a5_q", q_at_done, 8'hA5);
      check("a5_gnt0_pulses", gnt0_cnt - gp, 1);
      check("a5_pre_pulses", pre_cnt - pp, 1);
      tick(); tick();

      // tie and fairness from a fresh reset
      do_reset();
      DIN0 = 8'h0F; DIN1 = 8'hF0; REQ0 = 1'b1; REQ1 = 1'b1;
      run_until_done(30);
      check("tie1_id", last_id, 0);
      check("tie1_q", q_at_done, 8'h0F);
      prev_done = last_done_cyc;
      run_until_done(30);
      check("tie2_id", last_id, 1);
      check("tie2_q", q_at_done, 8'hF0);
      check("tie2_gnt_cycle", last_gnt1_cyc, prev_done + 2);
      DIN0 = N'($urandom); DIN1 = N'($urandom); REQ0 = 1'b1; REQ1 = 1'b1;
      run_until_done(30);
      check("tie3_id", last_id, 0);
      run_until_done(30);
      check("tie4_id", last_id, 1);

      // REQ1 pulse entirely inside a requester-0 shift is ignored
      g1 = gnt1_cnt; d = done_cnt;
      DIN0 = N'($urandom); REQ0 = 1'b1;
      for (int i = 0; i < 20 && s0_idx != 2; i++) tick();
      DIN1 = N'($urandom); REQ1 = 1'b1;
      for (int i = 0; i < 20 && s0_idx != 6; i++) tick();
      REQ1 = 1'b0;
      run_until_done(20);
      tick(); tick(); tick();
      check("ign_gnt1", gnt1_cnt - g1, 0);
      check("ign_done", done_cnt - d, 1);

      // reset in the third shift cycle, then a clean requester-1 load
      d = done_cnt;
      DIN0 = N'($urandom); REQ0 = 1'b1;
      for (int i = 0; i < 20 && s0_idx != 3; i++) tick();
      do_reset();
      repeat (4) tick();
      check("rst_no_done", done_cnt - d, 0);
      DIN1 = 8'h3C; REQ1 = 1'b1;
      run_until_done(30);
      check("rst_after_id", last_id, 1);
      check("rst_after_q", q_at_done, 8'h3C);
      tick(); tick();

      // back-to-back with REQ0 held high
      done_cycs.delete(); gnt0_cycs.delete();
      auto_drop = 1'b0;
      DIN0 = N'($urandom); REQ0 = 1'b1;
      for (int i = 0; i < 80 && done_cycs.size() < 4; i++) tick();
      REQ0 = 1'b0; auto_drop = 1'b1;
      check("b2b_count", done_cycs.size() >= 4, 1);
      for (int i = 0; i + 1 < done_cycs.size(); i++) begin
         check("b2b_spacing", done_cycs[i+1] - done_cycs[i], 11);
         if (i + 1 < gnt0_cycs.size()) check("b2b_gnt_after_done", gnt0_cycs[i+1], done_cycs[i] + 2);
      end
      repeat (15) tick();

      // random traffic, including requests abandoned before their grant
      repeat (400) begin
         if (!REQ0) begin
            if ($urandom_range(3) == 0) begin DIN0 = N'($urandom); REQ0 = 1'b1; end
         end else if ($urandom_range(15) == 0) REQ0 = 1'b0;
         if (!REQ1) begin
            if ($urandom_range(3) == 0) begin DIN1 = N'($urandom); REQ1 = 1'b1; end
         end else if ($urandom_range(15) == 0) REQ1 = 1'b0;
         tick();
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      repeat (15) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
